// File: rtl/olympus_wb_pkg.sv
// Shared types for the register-file write-back arbiter: FSM states, requester IDs,
// one-hot grant encodings and the hard-wired zero register.
package olympus_wb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } wbState_t;

  typedef enum logic [1:0] {
    SRC_PIPE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_MDU  = 2'd2
  } wbSrc_t;

  // One-hot grant, bit position equals the requester ID
  typedef logic [2:0] wbGrant_t;

  localparam wbGrant_t GNT_NONE = 3'b000;
  localparam wbGrant_t GNT_PIPE = 3'b001;
  localparam wbGrant_t GNT_LD   = 3'b010;
  localparam wbGrant_t GNT_MDU  = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy flags for destination registers of in-flight long-latency ops, the WAW
// issue check and the two decode-side busy lookups.
module wb_scoreboard
  import olympus_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iss_valid,
  input  logic [4:0] iss_rd,
  output logic       iss_ready,
  input  logic       clrEn,
  input  logic [4:0] clrRd,
  input  logic [4:0] rR1,
  input  logic [4:0] rR2,
  output logic       busy1,
  output logic       busy2
);

  logic [31:0] busyVec;
  logic        issSet;

  assign iss_ready = !busyVec[iss_rd] || (iss_rd == REG_ZERO);
  assign issSet    = iss_valid && iss_ready && (iss_rd != REG_ZERO);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : gBusy
      logic bitReg;
      logic setHit;
      logic clrHit;

      assign setHit = issSet && (iss_rd == 5'(gi));
      assign clrHit = clrEn && (clrRd == 5'(gi));

      // A new issue to the same register outranks the retiring write
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bitReg <= 1'b0;
        else if (setHit) bitReg <= 1'b1;
        else if (clrHit) bitReg <= 1'b0;
      end

      assign busyVec[gi] = bitReg;
    end
  endgenerate

  assign busy1 = (rR1 != REG_ZERO) && busyVec[rR1];
  assign busy2 = (rR2 != REG_ZERO) && busyVec[rR2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline priority, ld/mdu round-robin, anti-starvation
// HOLD state and in-flight scoreboard. RF_WB_BYPASS_EN adds output-stage forwarding ports.
module rf_wb_arbiter
  import olympus_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  output logic        pipe_hold,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_wd,
  output logic        ld_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  rR1,
  input  logic [4:0]  rR2,
  output logic        haz_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wR,
  output logic [31:0] rf_wD
`ifdef RF_WB_BYPASS_EN
  ,
  output logic        fwd1_sel,
  output logic        fwd2_sel,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
`endif
);

  localparam logic [3:0] LIM    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  wbState_t   stateReg, stateNext;
  wbSrc_t     rrLastReg;
  logic [3:0] ldCntReg, mduCntReg;
  wbGrant_t   grant, rrPick;
  logic       ldStarved, mduStarved, ldHit, mduHit;
  logic       busy1, busy2;
  logic       clrEn;
  logic [4:0] clrRd;

  assign ldStarved  = (ldCntReg == LIM);
  assign mduStarved = (mduCntReg == LIM);

  always_comb begin
    rrPick = GNT_NONE;
    if (ld_valid && mdu_valid) rrPick = (rrLastReg == SRC_LD) ? GNT_MDU : GNT_LD;
    else if (ld_valid)         rrPick = GNT_LD;
    else if (mdu_valid)        rrPick = GNT_MDU;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= NORMAL;
    else        stateReg <= stateNext;
  end

  // FSM: next state -- enter HOLD on the edge a waiting source's counter reaches the limit
  always_comb begin
    stateNext = NORMAL;
    if (stateReg == NORMAL && (ldHit || mduHit)) stateNext = HOLD;
  end

  // FSM: outputs
  always_comb begin
    grant     = GNT_NONE;
    pipe_hold = (stateReg == HOLD);
    if (stateReg == HOLD) begin
      if (ldStarved && ld_valid)        grant = GNT_LD;
      else if (mduStarved && mdu_valid) grant = GNT_MDU;
      else                              grant = rrPick;
    end else if (pipe_we) begin
      grant = GNT_PIPE;
    end else begin
      grant = rrPick;
    end
  end

  assign ld_ready  = (grant == GNT_LD);
  assign mdu_ready = (grant == GNT_MDU);
  assign ldHit     = ld_valid && !ld_ready && (ldCntReg >= LIM_M1);
  assign mduHit    = mdu_valid && !mdu_ready && (mduCntReg >= LIM_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldCntReg  <= '0;
      mduCntReg <= '0;
      rrLastReg <= SRC_LD;
    end else begin
      if (ld_ready)                        ldCntReg <= '0;
      else if (ld_valid && ldCntReg != LIM) ldCntReg <= ldCntReg + 4'd1;
      if (mdu_ready)                         mduCntReg <= '0;
      else if (mdu_valid && mduCntReg != LIM) mduCntReg <= mduCntReg + 4'd1;
      if (ld_ready)       rrLastReg <= SRC_LD;
      else if (mdu_ready) rrLastReg <= SRC_MDU;
    end
  end

  // Output stage; writes to r0 are accepted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wR <= '0;
      rf_wD <= '0;
    end else begin
      rf_we <= 1'b0;
      case (grant)
        GNT_PIPE: begin
          rf_we <= (pipe_rd != REG_ZERO);
          rf_wR <= pipe_rd;
          rf_wD <= pipe_wd;
        end
        GNT_LD: begin
          rf_we <= (ld_rd != REG_ZERO);
          rf_wR <= ld_rd;
          rf_wD <= ld_wd;
        end
        GNT_MDU: begin
          rf_we <= (mdu_rd != REG_ZERO);
          rf_wR <= mdu_rd;
          rf_wD <= mdu_wd;
        end
        default: ;
      endcase
    end
  end

  assign clrEn = ld_ready || mdu_ready;
  assign clrRd = ld_ready ? ld_rd : mdu_rd;

  wb_scoreboard uScoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clrEn     (clrEn),
    .clrRd     (clrRd),
    .rR1       (rR1),
    .rR2       (rR2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

`ifdef RF_WB_BYPASS_EN
  assign fwd1_sel  = rf_we && (rf_wR == rR1) && (rR1 != REG_ZERO);
  assign fwd2_sel  = rf_we && (rf_wR == rR2) && (rR2 != REG_ZERO);
  assign fwd1_data = rf_wD;
  assign fwd2_data = rf_wD;
  assign haz_stall = busy1 || busy2;
`else
  // The output-stage write only lands in the RF one edge later
  assign haz_stall = busy1 || busy2 ||
                     (rf_we && (rR1 != REG_ZERO) && (rf_wR == rR1)) ||
                     (rf_we && (rR2 != REG_ZERO) && (rf_wR == rR2));
`endif

endmodule
